// File: rtl/message_sequencer_if.sv
// Handshake bundle between the start requester and the message sequencer.
// The abort strobe only exists when MSG_SEQ_ABORT_EN is defined.
interface message_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             ld;
    logic             shift;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] bit_idx;
    logic             tick_co;
`ifdef MSG_SEQ_ABORT_EN
    logic             abort;

    modport master (
        output start, abort,
        input  ld, shift, busy, done, bit_idx, tick_co
    );

    modport slave (
        input  start, abort,
        output ld, shift, busy, done, bit_idx, tick_co
    );
`else
    modport master (
        output start,
        input  ld, shift, busy, done, bit_idx, tick_co
    );

    modport slave (
        input  start,
        output ld, shift, busy, done, bit_idx, tick_co
    );
`endif
endinterface

// File: rtl/message_sequencer.sv
// Control FSM for the message serialiser: loads the shift register on start,
// paces one shift every BIT_TICKS+1 cycles and pulses done when finished.
// Optional abort input is enabled by defining MSG_SEQ_ABORT_EN.
module message_sequencer #(
    parameter int MSG_BITS  = 6,
    parameter int BIT_TICKS = 1000,
    parameter int TICK_W    = 10,
    parameter int CNT_W     = 4
) (
    input logic                 clk,
    input logic                 rst,
    message_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0]  MSG_LAST  = CNT_W'(MSG_BITS);
    localparam logic [CNT_W-1:0]  IDX_ONE   = CNT_W'(1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

    state_t            state;
    state_t            state_next;
    logic [TICK_W-1:0] tick;
    logic [TICK_W-1:0] tick_next;
    logic [CNT_W-1:0]  bit_idx;
    logic [CNT_W-1:0]  bit_idx_next;
    logic [CNT_W-1:0]  bit_idx_inc;
    logic              abort_hit;

    assign bit_idx_inc = bit_idx + IDX_ONE;

    // Abort only matters while a message is in flight (LOAD, WAIT, SHIFT).
`ifdef MSG_SEQ_ABORT_EN
    assign abort_hit = bus.abort &&
                       ((state == LOAD) || (state == WAIT) || (state == SHIFT));
`else
    assign abort_hit = 1'b0;
`endif

    // State, prescaler and bit counter registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tick    <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_next;
            tick    <= tick_next;
            bit_idx <= bit_idx_next;
        end
    end

    // Next-state logic; counters default to zero so every exit path clears them.
    always_comb begin
        state_next   = IDLE;
        tick_next    = '0;
        bit_idx_next = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = WAIT;
            end
            WAIT: begin
                bit_idx_next = bit_idx;
                if (tick == TICK_LAST) begin
                    state_next = SHIFT;
                end else begin
                    state_next = WAIT;
                    tick_next  = tick + TICK_ONE;
                end
            end
            SHIFT: begin
                bit_idx_next = bit_idx_inc;
                if (bit_idx_inc == MSG_LAST) begin
                    state_next = DONE;
                end else begin
                    state_next = WAIT;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort_hit) begin
            state_next   = IDLE;
            tick_next    = '0;
            bit_idx_next = '0;
        end
    end

    // Strobes are decoded purely from registered state so they are glitch-free.
    assign bus.ld      = (state == LOAD);
    assign bus.shift   = (state == SHIFT);
    assign bus.done    = (state == DONE);
    assign bus.busy    = (state == LOAD) || (state == WAIT) || (state == SHIFT);
    assign bus.tick_co = (state == WAIT) && (tick == TICK_LAST);
    assign bus.bit_idx = bit_idx;

endmodule
